store_write_buffer: RTL and testbench



---
 rtl/store_write_buffer.sv | 141 ++++++++++++++
 tb/tb_store_write_buffer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// rtl/store_write_buffer.sv - posted-store FIFO write buffer with load bypass; WB_STORE_FWD_EN selects forwarding vs stall-on-match
module store_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic              w_empty;
  logic              w_full;
  logic              w_hit;
  logic              w_drain_fire;
  logic              w_store_accept;
`ifdef WB_STORE_FWD_EN
  logic [DATA_W-1:0] w_fwd_data;
`endif

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign count   = r_count;
  assign full    = w_full;
  assign empty   = w_empty;

  // Word-address match against valid entries, walking oldest to youngest so the youngest match wins
  always_comb begin
    w_hit = 1'b0;
`ifdef WB_STORE_FWD_EN
    w_fwd_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[r_head + PW'(i)] &&
          (r_addr[r_head + PW'(i)][ADDR_W-1:2] == cpu_addr[ADDR_W-1:2])) begin
        w_hit = 1'b1;
`ifdef WB_STORE_FWD_EN
        w_fwd_data = r_data[r_head + PW'(i)];
`endif
      end
    end
  end

`ifdef WB_STORE_FWD_EN
  // Loads own the memory port outright; the drain waits for a non-load cycle
  assign w_drain_fire = !w_empty && mem_ready && !cpu_mem_read;
`else
  // A load blocked by a matching entry lets the drain proceed so the match eventually clears
  assign w_drain_fire = !w_empty && mem_ready && (!cpu_mem_read || w_hit);
`endif

  assign w_store_accept = cpu_mem_write && (!w_full || w_drain_fire);

  // Memory port, load return data and pipeline stall
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    stall     = 1'b0;
    if (w_drain_fire) begin
      mem_write = 1'b1;
      mem_addr  = r_addr[r_head];
      mem_wdata = r_data[r_head];
    end
    if (cpu_mem_read) begin
`ifdef WB_STORE_FWD_EN
      mem_read = 1'b1;
      mem_addr = cpu_addr;
      if (w_hit) begin
        cpu_rdata = w_fwd_data;
      end else begin
        cpu_rdata = mem_rdata;
        stall     = !mem_ready;
      end
`else
      if (w_hit) begin
        stall = 1'b1;
      end else begin
        mem_read  = 1'b1;
        mem_addr  = cpu_addr;
        cpu_rdata = mem_rdata;
        stall     = !mem_ready;
      end
`endif
    end else if (cpu_mem_write && !w_store_accept) begin
      stall = 1'b1;
    end
  end

  // Queue state: retire head on drain, append at tail on accept; count tracks the net change
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_drain_fire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (w_store_accept) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= cpu_addr;
        r_data[r_tail]  <= cpu_wdata;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_store_accept && !w_drain_fire) begin
        r_count <= r_count + CW'(1);
      end else if (w_drain_fire && !w_store_accept) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// tb/tb_store_write_buffer.sv - self-checking bench for store_write_buffer against a queue-based reference model
module tb_store_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_mem_read = 1'b0;
  logic        cpu_mem_write = 1'b0;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic        rdy;
    logic        e_stall;
    logic        e_mw;
    logic [31:0] e_maddr;
    logic [31:0] e_wd;
    int          e_cnt;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  ent_t        q[$];
  ent_t        wlog[$];
  logic [31:0] mmem [logic [29:0]];

  logic        m_drain, m_accept, s_rn;
  logic [31:0] s_a, s_d;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mmem.exists(a[31:2])) return mmem[a[31:2]];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rn, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic rdy);
    logic hit, e_mr, e_mw, e_st;
    logic [31:0] fwd, e_ad, e_wd, e_rd;
    int n;
    @(negedge clk);
    reset = rn; cpu_mem_read = rd; cpu_mem_write = wr;
    cpu_addr = a; cpu_wdata = d; mem_ready = rdy;
    mem_rdata = mem_val(a);
    hit = 1'b0; fwd = '0;
    foreach (q[i]) if (q[i].a[31:2] == a[31:2]) begin hit = 1'b1; fwd = q[i].d; end
    n = q.size();
`ifdef WB_STORE_FWD_EN
    m_drain = (n > 0) && rdy && !rd;
`else
    m_drain = (n > 0) && rdy && (!rd || hit);
`endif
    m_accept = wr && ((n < DEPTH) || m_drain);
    e_mr = 0; e_mw = 0; e_st = 0; e_ad = '0; e_wd = '0; e_rd = '0;
    if (m_drain) begin e_mw = 1; e_ad = q[0].a; e_wd = q[0].d; end
    if (rd) begin
`ifdef WB_STORE_FWD_EN
      e_mr = 1; e_ad = a;
      if (hit) e_rd = fwd;
      else begin e_rd = mem_val(a); e_st = !rdy; end
`else
      if (hit) e_st = 1;
      else begin e_mr = 1; e_ad = a; e_rd = mem_val(a); e_st = !rdy; end
`endif
    end else if (wr && !m_accept) begin
      e_st = 1;
    end
    #1;
    if (rn) begin
      chk("stall", stall, e_st);
      chk("mem_read", mem_read, e_mr);
      chk("mem_write", mem_write, e_mw);
      chk("mem_addr", mem_addr, e_ad);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("cpu_rdata", cpu_rdata, e_rd);
      chk("count", count, n);
      chk("full", full, n == DEPTH);
      chk("empty", empty, n == 0);
      if (mem_write) wlog.push_back({mem_addr, mem_wdata});
    end
    s_rn = rn; s_a = a; s_d = d;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!s_rn) begin
      q.delete();
    end else begin
      if (m_drain) begin
        mmem[q[0].a[31:2]] = q[0].d;
        void'(q.pop_front());
      end
      if (m_accept) q.push_back({s_a, s_d});
    end
  endtask

  task automatic cycle(input logic rn, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input logic rdy);
    drive(rn, rd, wr, a, d, rdy);
    tick();
  endtask

  task automatic flush();
    for (int t = 0; t < 2 * DEPTH + 4 && q.size() > 0; t++) cycle(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    chk("flush_empty", empty, 1);
    tick();
  endtask

  vec_t tv[12];

  initial begin
    int  waited;
    bool_done: begin end
    tv[0]  = '{1, 32'h10, 32'd1, 0, 0, 0, 32'h0,  32'd0, 0};
    tv[1]  = '{1, 32'h14, 32'd2, 0, 0, 0, 32'h0,  32'd0, 1};
    tv[2]  = '{1, 32'h18, 32'd3, 0, 0, 0, 32'h0,  32'd0, 2};
    tv[3]  = '{1, 32'h1C, 32'd4, 0, 0, 0, 32'h0,  32'd0, 3};
    tv[4]  = '{1, 32'h20, 32'd5, 0, 1, 0, 32'h0,  32'd0, 4};
    tv[5]  = '{1, 32'h20, 32'd5, 1, 0, 1, 32'h10, 32'd1, 4};
    tv[6]  = '{0, 32'h0,  32'd0, 0, 0, 0, 32'h0,  32'd0, 4};
    tv[7]  = '{0, 32'h0,  32'd0, 1, 0, 1, 32'h14, 32'd2, 4};
    tv[8]  = '{0, 32'h0,  32'd0, 1, 0, 1, 32'h18, 32'd3, 3};
    tv[9]  = '{0, 32'h0,  32'd0, 1, 0, 1, 32'h1C, 32'd4, 2};
    tv[10] = '{0, 32'h0,  32'd0, 1, 0, 1, 32'h20, 32'd5, 1};
    tv[11] = '{0, 32'h0,  32'd0, 1, 0, 0, 32'h0,  32'd0, 0};

    s_rn = 0; s_a = '0; s_d = '0; m_drain = 0; m_accept = 0;
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // reset state
    drive(1, 0, 0, 0, 0, 1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_stall", stall, 0);
    chk("rst_rdata", cpu_rdata, 0);
    tick();

    // reset discards queued stores
    cycle(1, 0, 1, 32'h300, 32'h11, 0);
    cycle(1, 0, 1, 32'h304, 32'h22, 0);
    cycle(1, 0, 1, 32'h308, 32'h33, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("pre_rst_count", count, 3);
    tick();
    wlog.delete();
    cycle(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1);
    chk("post_rst_count", count, 0);
    chk("post_rst_empty", empty, 1);
    chk("post_rst_mw", mem_write, 0);
    tick();
    chk("post_rst_nowrites", wlog.size(), 0);

    // full buffer: blocked store, then simultaneous drain and accept
    foreach (tv[i]) begin
      drive(1, 0, tv[i].wr, tv[i].a, tv[i].d, tv[i].rdy);
      chk("tv_stall", stall, tv[i].e_stall);
      chk("tv_mem_write", mem_write, tv[i].e_mw);
      chk("tv_mem_addr", mem_addr, tv[i].e_maddr);
      chk("tv_mem_wdata", mem_wdata, tv[i].e_wd);
      chk("tv_count", count, tv[i].e_cnt);
      tick();
    end

    // duplicate-address stores then a load of that word
    cycle(1, 0, 1, 32'h40, 32'hAAAA, 0);
    cycle(1, 0, 1, 32'h40, 32'hBBBB, 0);
    drive(1, 1, 0, 32'h40, 0, 0);
`ifdef WB_STORE_FWD_EN
    chk("fwd_rdata", cpu_rdata, 32'hBBBB);
    chk("fwd_stall", stall, 0);
`else
    chk("hit_stall", stall, 1);
    chk("hit_mread", mem_read, 0);
    chk("hit_rdata", cpu_rdata, 0);
`endif
    tick();
    waited = -1;
    for (int k = 0; k < 10; k++) begin
      drive(1, 1, 0, 32'h40, 0, 1);
      if (!stall) begin
        waited = k;
        chk("load40_rdata", cpu_rdata, 32'hBBBB);
      end
      tick();
      if (waited >= 0) break;
    end
`ifdef WB_STORE_FWD_EN
    chk("load40_wait", waited, 0);
`else
    chk("load40_wait", waited, 2);
`endif
    flush();

    // load miss with queued stores, then drain on the next idle cycle
    cycle(1, 0, 1, 32'h60, 32'h6001, 0);
    cycle(1, 0, 1, 32'h64, 32'h6402, 0);
    drive(1, 1, 0, 32'h80, 0, 1);
    chk("miss_mread", mem_read, 1);
    chk("miss_mw", mem_write, 0);
    chk("miss_rdata", cpu_rdata, 32'h5A5A_0080);
    chk("miss_count", count, 2);
    tick();
    drive(1, 0, 0, 0, 0, 1);
    chk("after_miss_mw", mem_write, 1);
    chk("after_miss_addr", mem_addr, 32'h60);
    chk("after_miss_data", mem_wdata, 32'h6001);
    tick();
    flush();

    // nine stores with pointer wrap; memory sees program order
    wlog.delete();
    for (int i = 0; i < 9; i++) begin
      logic acc;
      acc = 0;
      for (int t = 0; t < 8 && !acc; t++) begin
        drive(1, 0, 1, 32'h200 + 32'(4 * (i % 5)), 32'h5000 + 32'(i), 1'(i % 2));
        acc = !stall;
        tick();
      end
      chk("wrap_accept", acc, 1);
      if (i % 3 != 2) cycle(1, 0, 0, 0, 0, 1'($urandom_range(0, 1)));
    end
    flush();
    chk("wrap_nwrites", wlog.size(), 9);
    for (int i = 0; i < 9 && i < wlog.size(); i++) begin
      chk("wrap_addr", wlog[i].a, 32'h200 + 32'(4 * (i % 5)));
      chk("wrap_data", wlog[i].d, 32'h5000 + 32'(i));
    end

    // randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      int sel;
      logic [31:0] a;
      sel = $urandom_range(0, 3);
      a = 32'h100 + 32'(4 * $urandom_range(0, 5));
      cycle(1, sel == 1, sel >= 2, a, $urandom, $urandom_range(0, 3) != 0);
    end
    flush();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
